// File: rtl/cpu_ex_pkg.sv
// Shared types and defaults for the execute stage: ALU opcodes, FSM states and
// the EX/MEM load selector.
package cpu_ex_pkg;

  localparam int XLEN_DEF      = 32;
  localparam int MUL_ITERS_DEF = 32;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_PASSB = 4'd10,
    ALU_MUL   = 4'd11
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    WAIT = 2'd2
  } ex_state_t;

  typedef enum logic [1:0] {
    LD_HOLD   = 2'd0,
    LD_BUBBLE = 2'd1,
    LD_ALU    = 2'd2,
    LD_PROD   = 2'd3
  } exmem_ld_t;

endpackage

// File: rtl/ex_stage_if.sv
// EX/MEM pipeline register bus. master = execute stage, slave = MEM stage
// and forwarding unit.
interface ex_stage_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 4
);
  logic              mem_stall;
  logic              mem_valid;
  logic [XLEN-1:0]   mem_alu_out;
  logic [XLEN-1:0]   mem_store_data;
  logic [REG_AW-1:0] mem_reg_dst;
  logic              mem_reg_wr;
  logic              mem_wb_sel;
  logic              mem_mem_wr;

  modport master (
    input  mem_stall,
    output mem_valid, mem_alu_out, mem_store_data, mem_reg_dst,
           mem_reg_wr, mem_wb_sel, mem_mem_wr
  );

  modport slave (
    output mem_stall,
    input  mem_valid, mem_alu_out, mem_store_data, mem_reg_dst,
           mem_reg_wr, mem_wb_sel, mem_mem_wr
  );
endinterface

// File: rtl/ex_iter_mul.sv
// Iterative shift-add multiplier, one partial product per step.
// product already includes the current step's addend, so it is final on the done edge.
module ex_iter_mul #(
  parameter int XLEN      = 32,
  parameter int MUL_ITERS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            step,
  input  logic            abort,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] product
);
  localparam int            CW   = $clog2(MUL_ITERS);
  localparam logic [CW-1:0] LAST = CW'(MUL_ITERS - 1);

  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] acc;
  logic [CW-1:0]   cnt;

  // Once the multiplier has shifted out, product settles to acc and holds.
  assign product = mplier[0] ? (acc + mcand) : acc;
  assign done    = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || abort) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
    end else if (step) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand select, single-cycle ALU, iterative multiply and the
// registered EX/MEM output.
//
// state | meaning
// IDLE  | accepting instructions; EX/MEM follows the ALU or bubbles
// MUL   | multiply iterating; upstream stalled, EX/MEM bubbles
// WAIT  | product ready but MEM stalled; product held until it can load
module ex_stage
  import cpu_ex_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int REG_AW    = 4,
  parameter int MUL_ITERS = MUL_ITERS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic              rs1_sel,
  input  logic              rs2_sel,
  input  logic [XLEN-1:0]   ex_rs1_forward,
  input  logic [XLEN-1:0]   ex_rs2_forward,
  input  logic [XLEN-1:0]   imm,
  input  logic              use_imm,
  input  logic [3:0]        alu_op,
  input  logic [REG_AW-1:0] rd,
  input  logic              reg_wr,
  input  logic              mem_rd,
  input  logic              mem_wr_en,
  input  logic              flush,
  output logic              ex_stall,
  ex_stage_if.master        mem_if
);
  localparam int SHW = $clog2(XLEN);

  ex_state_t         state, state_nxt;
  exmem_ld_t         ld_sel;
  logic              accept, is_mul, mul_start, mul_step, mul_done;
  logic [XLEN-1:0]   op_a, rs2_val, op_b, alu_res, mul_product;
  logic [SHW-1:0]    shamt;

  logic [REG_AW-1:0] mul_rd;
  logic              mul_reg_wr, mul_wb_sel, mul_mem_wr;
  logic [XLEN-1:0]   mul_store;

  assign op_a    = rs1_sel ? ex_rs1_forward : id_rs1_data;
  assign rs2_val = rs2_sel ? ex_rs2_forward : id_rs2_data;
  assign op_b    = use_imm ? imm : rs2_val;
  assign shamt   = op_b[SHW-1:0];
  assign is_mul  = (alu_op == ALU_MUL);

  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD:   alu_res = op_a + op_b;
      ALU_SUB:   alu_res = op_a - op_b;
      ALU_AND:   alu_res = op_a & op_b;
      ALU_OR:    alu_res = op_a | op_b;
      ALU_XOR:   alu_res = op_a ^ op_b;
      ALU_SLL:   alu_res = op_a << shamt;
      ALU_SRL:   alu_res = op_a >> shamt;
      ALU_SRA:   alu_res = $unsigned($signed(op_a) >>> shamt);
      ALU_SLT:   alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU:  alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      ALU_PASSB: alu_res = op_b;
      default:   alu_res = '0;
    endcase
  end

  ex_iter_mul #(.XLEN(XLEN), .MUL_ITERS(MUL_ITERS)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .step    (mul_step),
    .abort   (flush),
    .a       (op_a),
    .b       (op_b),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (mul_start) state_nxt = MUL;
        MUL:     if (mul_done) state_nxt = mem_if.mem_stall ? WAIT : IDLE;
        WAIT:    if (!mem_if.mem_stall) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    ex_stall  = rst_n & ((state != IDLE) | mem_if.mem_stall);
    accept    = in_valid & ~ex_stall & ~flush;
    mul_start = accept & is_mul;
    mul_step  = (state == MUL) & ~flush;
    ld_sel    = LD_HOLD;
    // Flush squashes EX/MEM even while MEM is stalled.
    if (flush) begin
      ld_sel = LD_BUBBLE;
    end else if (!mem_if.mem_stall) begin
      case (state)
        IDLE:    ld_sel = (accept && !is_mul) ? LD_ALU : LD_BUBBLE;
        MUL:     ld_sel = mul_done ? LD_PROD : LD_BUBBLE;
        WAIT:    ld_sel = LD_PROD;
        default: ld_sel = LD_BUBBLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mul_rd     <= '0;
      mul_reg_wr <= 1'b0;
      mul_wb_sel <= 1'b0;
      mul_mem_wr <= 1'b0;
      mul_store  <= '0;
    end else if (mul_start) begin
      mul_rd     <= rd;
      mul_reg_wr <= reg_wr;
      mul_wb_sel <= mem_rd;
      mul_mem_wr <= mem_wr_en;
      mul_store  <= rs2_val;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_if.mem_valid      <= 1'b0;
      mem_if.mem_alu_out    <= '0;
      mem_if.mem_store_data <= '0;
      mem_if.mem_reg_dst    <= '0;
      mem_if.mem_reg_wr     <= 1'b0;
      mem_if.mem_wb_sel     <= 1'b0;
      mem_if.mem_mem_wr     <= 1'b0;
    end else begin
      case (ld_sel)
        LD_BUBBLE: begin
          mem_if.mem_valid  <= 1'b0;
          mem_if.mem_reg_wr <= 1'b0;
          mem_if.mem_wb_sel <= 1'b0;
          mem_if.mem_mem_wr <= 1'b0;
        end
        LD_ALU: begin
          mem_if.mem_valid      <= 1'b1;
          mem_if.mem_alu_out    <= alu_res;
          mem_if.mem_store_data <= rs2_val;
          mem_if.mem_reg_dst    <= rd;
          mem_if.mem_reg_wr     <= reg_wr;
          mem_if.mem_wb_sel     <= mem_rd;
          mem_if.mem_mem_wr     <= mem_wr_en;
        end
        LD_PROD: begin
          mem_if.mem_valid      <= 1'b1;
          mem_if.mem_alu_out    <= mul_product;
          mem_if.mem_store_data <= mul_store;
          mem_if.mem_reg_dst    <= mul_rd;
          mem_if.mem_reg_wr     <= mul_reg_wr;
          mem_if.mem_wb_sel     <= mul_wb_sel;
          mem_if.mem_mem_wr     <= mul_mem_wr;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage: operand select, ALU ops, multiply
// timing, MEM stall/WAIT, flush and mid-multiply reset.
module tb_ex_stage;
  import cpu_ex_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] id_rs1_data, id_rs2_data, ex_rs1_forward, ex_rs2_forward, imm;
  logic        rs1_sel, rs2_sel, use_imm;
  logic [3:0]  alu_op;
  logic [3:0]  rd;
  logic        reg_wr, mem_rd, mem_wr_en, flush;
  logic        ex_stall;

  int checks   = 0;
  int failures = 0;

  ex_stage_if #(.XLEN(32), .REG_AW(4)) bus ();

  ex_stage #(.XLEN(32), .REG_AW(4), .MUL_ITERS(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .id_rs1_data    (id_rs1_data),
    .id_rs2_data    (id_rs2_data),
    .rs1_sel        (rs1_sel),
    .rs2_sel        (rs2_sel),
    .ex_rs1_forward (ex_rs1_forward),
    .ex_rs2_forward (ex_rs2_forward),
    .imm            (imm),
    .use_imm        (use_imm),
    .alu_op         (alu_op),
    .rd             (rd),
    .reg_wr         (reg_wr),
    .mem_rd         (mem_rd),
    .mem_wr_en      (mem_wr_en),
    .flush          (flush),
    .ex_stall       (ex_stall),
    .mem_if         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] dst);
    in_valid    = 1'b1;
    rs1_sel     = 1'b0;
    rs2_sel     = 1'b0;
    use_imm     = 1'b0;
    id_rs1_data = a;
    id_rs2_data = b;
    alu_op      = op;
    rd          = dst;
    reg_wr      = 1'b1;
    mem_rd      = 1'b0;
    mem_wr_en   = 1'b0;
  endtask

  logic [3:0]  t_op  [10];
  logic [31:0] t_a   [10];
  logic [31:0] t_b   [10];
  logic [31:0] t_exp [10];

  initial begin
    int n;
    int bad;

    t_op[0] = ALU_AND;   t_a[0] = 32'hF0F0_1234; t_b[0] = 32'h0FF0_FF00; t_exp[0] = 32'h00F0_1200;
    t_op[1] = ALU_OR;    t_a[1] = 32'hF000_0000; t_b[1] = 32'h0000_000F; t_exp[1] = 32'hF000_000F;
    t_op[2] = ALU_XOR;   t_a[2] = 32'hFFFF_0000; t_b[2] = 32'h0F0F_0F0F; t_exp[2] = 32'hF0F0_0F0F;
    t_op[3] = ALU_SLL;   t_a[3] = 32'h0000_0001; t_b[3] = 32'h0000_001F; t_exp[3] = 32'h8000_0000;
    t_op[4] = ALU_SRL;   t_a[4] = 32'h8000_0000; t_b[4] = 32'h0000_0021; t_exp[4] = 32'h4000_0000;
    t_op[5] = ALU_PASSB; t_a[5] = 32'h0000_0000; t_b[5] = 32'h1234_5678; t_exp[5] = 32'h1234_5678;
    t_op[6] = ALU_SRA;   t_a[6] = 32'h8000_0000; t_b[6] = 32'h0000_0024; t_exp[6] = 32'hF800_0000;
    t_op[7] = ALU_SLT;   t_a[7] = 32'hFFFF_FFFF; t_b[7] = 32'h0000_0001; t_exp[7] = 32'h0000_0001;
    t_op[8] = ALU_SLTU;  t_a[8] = 32'hFFFF_FFFF; t_b[8] = 32'h0000_0001; t_exp[8] = 32'h0000_0000;
    t_op[9] = 4'd12;     t_a[9] = 32'h0000_0005; t_b[9] = 32'h0000_0006; t_exp[9] = 32'h0000_0000;

    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; bus.mem_stall = 1'b1;
    id_rs1_data = '0; id_rs2_data = '0; ex_rs1_forward = '0; ex_rs2_forward = '0; imm = '0;
    rs1_sel = 1'b0; rs2_sel = 1'b0; use_imm = 1'b0; alu_op = '0; rd = '0;
    reg_wr = 1'b0; mem_rd = 1'b0; mem_wr_en = 1'b0;
    tick();
    tick();
    chk("rst_stall_low", 32'(ex_stall), 32'd0);
    bus.mem_stall = 1'b0;
    rst_n = 1'b1;
    chk("rst_valid", 32'(bus.mem_valid), 32'd0);
    chk("rst_alu_out", bus.mem_alu_out, 32'd0);
    chk("rst_reg_wr", 32'(bus.mem_reg_wr), 32'd0);
    chk("rst_ex_stall", 32'(ex_stall), 32'd0);

    // Forwarded rs1 plus immediate; forwarded rs2 becomes store data
    set_op(ALU_ADD, 32'd5, 32'd9, 4'd2);
    ex_rs1_forward = 32'd7; rs1_sel = 1'b1;
    imm = 32'd3; use_imm = 1'b1;
    ex_rs2_forward = 32'h55; rs2_sel = 1'b1;
    tick();
    chk("fwd_alu_out", bus.mem_alu_out, 32'd10);
    chk("fwd_reg_dst", 32'(bus.mem_reg_dst), 32'd2);
    chk("fwd_reg_wr", 32'(bus.mem_reg_wr), 32'd1);
    chk("fwd_valid", 32'(bus.mem_valid), 32'd1);
    chk("fwd_store", bus.mem_store_data, 32'h55);
    in_valid = 1'b0;
    tick();
    chk("bubble_valid", 32'(bus.mem_valid), 32'd0);
    chk("bubble_reg_wr", 32'(bus.mem_reg_wr), 32'd0);

    // Store and load control paths
    set_op(ALU_ADD, 32'h100, 32'hDEAD, 4'd1);
    imm = 32'd4; use_imm = 1'b1; reg_wr = 1'b0; mem_wr_en = 1'b1;
    tick();
    chk("st_alu_out", bus.mem_alu_out, 32'h104);
    chk("st_mem_wr", 32'(bus.mem_mem_wr), 32'd1);
    chk("st_reg_wr", 32'(bus.mem_reg_wr), 32'd0);
    chk("st_data", bus.mem_store_data, 32'hDEAD);
    set_op(ALU_ADD, 32'h200, 32'd8, 4'd3);
    mem_rd = 1'b1;
    tick();
    chk("ld_wb_sel", 32'(bus.mem_wb_sel), 32'd1);
    chk("ld_mem_wr", 32'(bus.mem_mem_wr), 32'd0);
    chk("ld_alu_out", bus.mem_alu_out, 32'h208);

    // Back-to-back single-cycle ops
    for (int i = 0; i < 10; i++) begin
      set_op(t_op[i], t_a[i], t_b[i], 4'(i));
      tick();
      chk($sformatf("alu_op%0d", t_op[i]), bus.mem_alu_out, t_exp[i]);
      chk($sformatf("alu_valid%0d", i), 32'(bus.mem_valid), 32'd1);
    end

    // MEM stall in IDLE holds EX/MEM and refuses the input
    set_op(ALU_ADD, 32'd10, 32'd20, 4'd7);
    tick();
    chk("add30", bus.mem_alu_out, 32'd30);
    set_op(ALU_ADD, 32'd1, 32'd1, 4'd8);
    bus.mem_stall = 1'b1;
    tick();
    chk("idle_stall_hold", bus.mem_alu_out, 32'd30);
    chk("idle_stall_dst", 32'(bus.mem_reg_dst), 32'd7);
    chk("idle_stall_ex", 32'(ex_stall), 32'd1);
    bus.mem_stall = 1'b0;
    tick();
    chk("idle_stall_release", bus.mem_alu_out, 32'd2);
    in_valid = 1'b0;

    // Multiply with no downstream stall
    set_op(ALU_MUL, 32'hFFFF_FFFF, 32'd3, 4'd3);
    tick();
    in_valid = 1'b0;
    n = 0; bad = 0;
    while (ex_stall && n < 100) begin
      n++;
      if (bus.mem_valid !== 1'b0) bad++;
      tick();
    end
    chk("mul_stall_cycles", 32'(n), 32'd32);
    chk("mul_bubbles", 32'(bad), 32'd0);
    chk("mul_product", bus.mem_alu_out, 32'hFFFF_FFFD);
    chk("mul_valid", 32'(bus.mem_valid), 32'd1);
    chk("mul_dst", 32'(bus.mem_reg_dst), 32'd3);
    set_op(ALU_ADD, 32'd2, 32'd3, 4'd9);
    tick();
    chk("post_mul_add", bus.mem_alu_out, 32'd5);
    chk("post_mul_dst", 32'(bus.mem_reg_dst), 32'd9);

    // Multiply completing into a MEM stall
    set_op(ALU_MUL, 32'h271, 32'd5, 4'd4);
    tick();
    in_valid = 1'b0;
    repeat (31) tick();
    bus.mem_stall = 1'b1;
    tick();
    chk("wait_state", 32'(dut.state), 32'(WAIT));
    chk("wait_valid", 32'(bus.mem_valid), 32'd0);
    chk("wait_hold", bus.mem_alu_out, 32'd5);
    repeat (3) tick();
    chk("wait_hold4", bus.mem_alu_out, 32'd5);
    chk("wait_stall", 32'(ex_stall), 32'd1);
    bus.mem_stall = 1'b0;
    tick();
    chk("wait_product", bus.mem_alu_out, 32'h0000_0C35);
    chk("wait_out_valid", 32'(bus.mem_valid), 32'd1);
    chk("wait_out_dst", 32'(bus.mem_reg_dst), 32'd4);
    chk("wait_to_idle", 32'(dut.state), 32'(IDLE));

    // Flush at iteration 10 with a same-cycle input
    set_op(ALU_MUL, 32'd7, 32'd9, 4'd5);
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    set_op(ALU_ADD, 32'd1, 32'd1, 4'd6);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", 32'(bus.mem_valid), 32'd0);
    chk("flush_stall", 32'(ex_stall), 32'd0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.mem_valid === 1'b1) n++;
      tick();
    end
    chk("flush_no_product", 32'(n), 32'd0);
    chk("flush_data_kept", bus.mem_alu_out, 32'h0000_0C35);

    // Flush beats MEM stall
    set_op(ALU_ADD, 32'd1, 32'd1, 4'd1);
    tick();
    chk("pre_flush_valid", 32'(bus.mem_valid), 32'd1);
    bus.mem_stall = 1'b1; flush = 1'b1;
    tick();
    chk("flush_over_stall", 32'(bus.mem_valid), 32'd0);
    chk("flush_over_stall_wr", 32'(bus.mem_reg_wr), 32'd0);
    bus.mem_stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
    tick();

    // Reset mid-multiply
    set_op(ALU_MUL, 32'd7, 32'd9, 4'd5);
    id_rs2_data = 32'h77;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0; bus.mem_stall = 1'b1;
    tick();
    chk("mrst_alu_out", bus.mem_alu_out, 32'd0);
    chk("mrst_dst", 32'(bus.mem_reg_dst), 32'd0);
    chk("mrst_valid", 32'(bus.mem_valid), 32'd0);
    chk("mrst_ex_stall", 32'(ex_stall), 32'd0);
    chk("mrst_state", 32'(dut.state), 32'(IDLE));
    rst_n = 1'b1; bus.mem_stall = 1'b0;
    set_op(ALU_SUB, 32'd3, 32'd5, 4'd2);
    tick();
    chk("sub_after_rst", bus.mem_alu_out, 32'hFFFF_FFFE);
    chk("sub_valid", 32'(bus.mem_valid), 32'd1);
    in_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 16-register, 32-bit pipelined CPU. Sits directly downstream of the forwarding unit.
- Selects each operand from either the ID/EX register value or the forwarded value. Executes single-cycle ALU ops and a 32-iteration shift-add multiply.
- Drives the registered EX/MEM interface that the MEM stage and the forwarding unit consume.
- Stalls upstream while a multiply is in progress and honours downstream stall and branch flush.

Parameters:
- XLEN, 32, datapath width.
- REG_AW, 4, register index width.
- MUL_ITERS, 32, multiply iterations; must equal XLEN.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  ID/EX holds a valid instruction.
- id_rs1_data  in  XLEN  rs1 value from the ID/EX register.
- id_rs2_data  in  XLEN  rs2 value from the ID/EX register.
- rs1_sel  in  1  1 = use ex_rs1_forward for operand A.
- rs2_sel  in  1  1 = use ex_rs2_forward for the rs2 value.
- ex_rs1_forward  in  XLEN  forwarded rs1 value.
- ex_rs2_forward  in  XLEN  forwarded rs2 value.
- imm  in  XLEN  sign-extended immediate.
- use_imm  in  1  operand B = imm instead of the rs2 value.
- alu_op  in  4  operation code (alu_op_t).
- rd  in  REG_AW  destination register.
- reg_wr  in  1  instruction writes rd.
- mem_rd  in  1  load; passed through as mem_wb_sel.
- mem_wr_en  in  1  store.
- mem_stall  in  1  MEM stage cannot accept.
- flush  in  1  squash the in-flight EX instruction (branch taken).
- ex_stall  out  1  upstream must hold ID/EX.
- mem_valid  out  1  EX/MEM holds a valid instruction.
- mem_alu_out  out  XLEN  result; feeds the forwarding unit's mem_reg_data1.
- mem_store_data  out  XLEN  selected rs2 value.
- mem_reg_dst  out  REG_AW  destination.
- mem_reg_wr  out  1  write enable, gated by valid.
- mem_wb_sel  out  1  load select.
- mem_mem_wr  out  1  store enable, gated by valid.

Behaviour:
- Operand selection:
  - A = rs1_sel ? ex_rs1_forward : id_rs1_data.
  - R2 = rs2_sel ? ex_rs2_forward : id_rs2_data.
  - B = use_imm ? imm : R2.
- Accept condition: in_valid & !ex_stall & !flush.
- ex_stall = (state != IDLE) | mem_stall. This is combinational.
- ALU ops (all results mod 2^32):
  - ADD 0: A+B. SUB 1: A-B. AND 2. OR 3. XOR 4.
  - SLL 5, SRL 6, SRA 7: shift amount = B[4:0].
  - SLT 8: signed compare, result 1 or 0. SLTU 9: unsigned compare, result 1 or 0.
  - PASSB 10: result = B.
  - MUL 11: low 32 bits of A*B.
  - Codes 12-15: result 0, control passed through unchanged.
- Single-cycle op accepted at edge E: EX/MEM outputs update at E and are visible the following cycle. Latency is 1.
- State machine: IDLE, MUL, WAIT.
  - IDLE:
    - Accepting MUL: capture A, B and control; clear the accumulator and cnt=0; go to MUL. At the same edge EX/MEM loads a bubble: mem_valid=0, reg_wr=0, mem_wr=0.
    - Accepting a non-MUL op: load EX/MEM with the result.
    - Nothing accepted and !mem_stall: load a bubble.
  - MUL:
    - Each edge performs one iteration: if multiplier bit0 is set, acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; cnt++.
    - On the edge where cnt==MUL_ITERS-1 and !mem_stall: write the product to EX/MEM (mem_valid=1) and go to IDLE.
    - If mem_stall is high at that edge: go to WAIT with the product held.
    - EX/MEM holds a bubble throughout; while mem_stall is high EX/MEM holds its contents.
  - WAIT: when mem_stall goes low, write the product to EX/MEM and go to IDLE.
- MUL timing: product visible 32 edges after accept if mem_stall stays low. ex_stall is high for exactly 32 cycles.
- mem_stall high in IDLE: EX/MEM holds all values and nothing is accepted.
- flush: next state IDLE. Any multiply is aborted. EX/MEM loads a bubble even when mem_stall is high, so flush has priority over mem_stall. A same-cycle in_valid is dropped.
- Reset (rst_n=0 at an edge):
  - All outputs, data included, go to 0 and state goes to IDLE. This has priority over everything and applies mid-multiply too.
  - ex_stall reads 0 while rst_n is low.
- mem_reg_wr and mem_mem_wr are never 1 while mem_valid=0.

Decomposition:
- Package cpu_ex_pkg:
  - alu_op_t enum (codes above).
  - ex_state_t enum {IDLE, MUL, WAIT}.
  - XLEN_DEF=32, MUL_ITERS_DEF=32.
- Sub-module ex_iter_mul:
  - Signals: start, operands, step enable, abort, done, product.
  - Holds the multiplicand, multiplier, accumulator and count registers.
  - The top level owns operand muxing, the ALU, the state machine and the EX/MEM register.

Test Plan:
1. Forward select: id_rs1_data=5, ex_rs1_forward=7, rs1_sel=1, B=imm=3, use_imm=1, ADD, rd=2, reg_wr=1 -> next cycle mem_alu_out=10, mem_reg_dst=2, mem_reg_wr=1, mem_valid=1.
2. Shifts and compares:
   - SRA A=0x80000000, B=0x24 -> 0xF8000000 (shift 4).
   - SLT A=-1, B=1 -> 1.
   - SLTU same operands -> 0.
3. MUL A=0xFFFFFFFF, B=3 -> ex_stall high for 32 cycles, bubbles meanwhile; mem_alu_out=0xFFFFFFFD on cycle 33; the next ADD is accepted right after.
4. MUL with mem_stall held high over the completion edge for 4 cycles -> state WAIT, EX/MEM unchanged; product 0x00000C35 (A=0x271, B=5) appears the cycle after mem_stall drops.
5. flush asserted at MUL iteration 10, with in_valid=1 in the same cycle -> next cycle mem_valid=0, ex_stall=0, the input is dropped and no product is ever written.
6. rst_n low for one edge mid-multiply -> all outputs 0, state IDLE; a subsequent SUB 3-5 gives 0xFFFFFFFE.
